// File: rtl/ex_muldiv_unit_pkg.sv
// Shared types and constants for the iterative RV32M multiply/divide unit.
package ex_muldiv_unit_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned ACC_W      = 2 * XLEN;
    localparam int unsigned RD_W       = 5;
    localparam int unsigned ITER_COUNT = 32;
    localparam int unsigned CNT_W      = $clog2(ITER_COUNT);

    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_DIV    = 3'd4,
        OP_DIVU   = 3'd5,
        OP_REM    = 3'd6,
        OP_REMU   = 3'd7
    } muldiv_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic logic op_is_div(input muldiv_op_e op);
        return (op == OP_DIV) || (op == OP_DIVU) || (op == OP_REM) || (op == OP_REMU);
    endfunction

    function automatic logic op_is_rem(input muldiv_op_e op);
        return (op == OP_REM) || (op == OP_REMU);
    endfunction

    function automatic logic op_signed_a(input muldiv_op_e op);
        return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic op_signed_b(input muldiv_op_e op);
        return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    endfunction

endpackage

// File: rtl/ex_muldiv_unit_if.sv
// ID/EX-side request and EX/MEM-side response bundle of the mul/div unit.
interface ex_muldiv_unit_if;
    import ex_muldiv_unit_pkg::*;

    logic               start;
    muldiv_op_e         op;
    logic [XLEN-1:0]    operand_a;
    logic [XLEN-1:0]    operand_b;
    logic [RD_W-1:0]    rd_in;
    logic               flush;
    logic [XLEN-1:0]    result;
    logic [RD_W-1:0]    rd_out;
    logic               done;
    logic               busy;
    logic               stall_req;

    modport master (
        output start, op, operand_a, operand_b, rd_in, flush,
        input  result, rd_out, done, busy, stall_req
    );

    modport slave (
        input  start, op, operand_a, operand_b, rd_in, flush,
        output result, rd_out, done, busy, stall_req
    );

endinterface

// File: rtl/muldiv_iter_step.sv
// One shift-add multiply step or one restoring-divide step on a shared 64-bit accumulator.
module muldiv_iter_step
    import ex_muldiv_unit_pkg::*;
(
    input  logic             is_div_i,
    input  logic [ACC_W-1:0] acc_i,
    input  logic [XLEN-1:0]  operand_i,
    output logic [ACC_W-1:0] acc_o,
    output logic             q_bit_o
);

    logic [XLEN:0]   add_sum;
    logic [XLEN:0]   rem_sh;
    logic            q_bit;
    logic [XLEN-1:0] rem_new;

    always_comb begin
        // Multiply: acc = {partial product, remaining multiplier bits}
        add_sum = {1'b0, acc_i[ACC_W-1:XLEN]} + {1'b0, operand_i};

        // Divide: acc = {remainder, remaining dividend / quotient bits}
        rem_sh  = {acc_i[ACC_W-1:XLEN], acc_i[XLEN-1]};
        q_bit   = (rem_sh >= {1'b0, operand_i});
        rem_new = q_bit ? XLEN'(rem_sh - {1'b0, operand_i}) : rem_sh[XLEN-1:0];

        acc_o   = '0;
        q_bit_o = 1'b0;
        if (is_div_i) begin
            // Quotient bit is returned separately and merged into bit 0 by the caller
            acc_o   = {rem_new, acc_i[XLEN-2:0], 1'b0};
            q_bit_o = q_bit;
        end else if (acc_i[0]) begin
            acc_o = {add_sum, acc_i[XLEN-1:1]};
        end else begin
            acc_o = {1'b0, acc_i[ACC_W-1:XLEN], acc_i[XLEN-1:1]};
        end
    end

endmodule

// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide unit: 32-cycle shift-add / restoring divide with
// magnitude operands, final sign fixup, stall request while busy and a one-cycle done.
module ex_muldiv_unit
    import ex_muldiv_unit_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    ex_muldiv_unit_if.slave   bus
);

    state_e           state_q, state_d;
    muldiv_op_e       op_q, op_d;
    logic [RD_W-1:0]  rd_q, rd_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [XLEN-1:0]  opnd_q, opnd_d;
    logic             neg_q, neg_d;
    logic [XLEN-1:0]  result_q, result_d;
    logic [RD_W-1:0]  rd_out_q, rd_out_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;

    logic             in_sa, in_sb;
    logic [XLEN-1:0]  abs_a, abs_b;
    logic             div_zero, div_ovf;
    logic             is_div_q;

    logic [ACC_W-1:0] step_acc;
    logic             step_q_bit;
    logic [ACC_W-1:0] step_full;
    logic [ACC_W-1:0] prod_fix;
    logic [XLEN-1:0]  div_sel, div_fix, mul_sel, final_res;

    assign is_div_q = op_is_div(op_q);

    muldiv_iter_step u_step (
        .is_div_i  (is_div_q),
        .acc_i     (acc_q),
        .operand_i (opnd_q),
        .acc_o     (step_acc),
        .q_bit_o   (step_q_bit)
    );

    // Operand magnitudes and short-circuit detection for the incoming instruction
    always_comb begin
        in_sa    = op_signed_a(bus.op) & bus.operand_a[XLEN-1];
        in_sb    = op_signed_b(bus.op) & bus.operand_b[XLEN-1];
        abs_a    = in_sa ? XLEN'(-bus.operand_a) : bus.operand_a;
        abs_b    = in_sb ? XLEN'(-bus.operand_b) : bus.operand_b;
        div_zero = op_is_div(bus.op) && (bus.operand_b == '0);
        div_ovf  = ((bus.op == OP_DIV) || (bus.op == OP_REM)) &&
                   (bus.operand_a == {1'b1, {(XLEN-1){1'b0}}}) &&
                   (bus.operand_b == '1);
    end

    // Final-iteration result with sign fixup applied
    always_comb begin
        step_full = {step_acc[ACC_W-1:1], step_acc[0] | step_q_bit};
        prod_fix  = neg_q ? ACC_W'(-step_full) : step_full;
        mul_sel   = (op_q == OP_MUL) ? prod_fix[XLEN-1:0] : prod_fix[ACC_W-1:XLEN];
        div_sel   = op_is_rem(op_q) ? step_full[ACC_W-1:XLEN] : step_full[XLEN-1:0];
        div_fix   = neg_q ? XLEN'(-div_sel) : div_sel;
        final_res = is_div_q ? div_fix : mul_sel;
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        rd_d     = rd_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opnd_d   = opnd_q;
        neg_d    = neg_q;
        result_d = result_q;
        rd_out_d = rd_out_q;
        done_d   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.start && !bus.flush) begin
                    op_d = bus.op;
                    rd_d = bus.rd_in;
                    if (div_zero) begin
                        result_d = op_is_rem(bus.op) ? bus.operand_a : '1;
                        rd_out_d = bus.rd_in;
                        done_d   = 1'b1;
                        state_d  = ST_DONE;
                    end else if (div_ovf) begin
                        result_d = (bus.op == OP_DIV) ? {1'b1, {(XLEN-1){1'b0}}} : '0;
                        rd_out_d = bus.rd_in;
                        done_d   = 1'b1;
                        state_d  = ST_DONE;
                    end else begin
                        // Divide iterates on |a| / |b|; multiply adds |a| under the bits of |b|
                        acc_d   = {{XLEN{1'b0}}, op_is_div(bus.op) ? abs_a : abs_b};
                        opnd_d  = op_is_div(bus.op) ? abs_b : abs_a;
                        neg_d   = op_is_rem(bus.op) ? in_sa : (in_sa ^ in_sb);
                        cnt_d   = '0;
                        state_d = ST_CALC;
                    end
                end
            end
            ST_CALC: begin
                if (bus.flush) begin
                    state_d = ST_IDLE;
                end else begin
                    acc_d = step_full;
                    cnt_d = CNT_W'(cnt_q + 1'b1);
                    if (cnt_q == CNT_W'(ITER_COUNT - 1)) begin
                        result_d = final_res;
                        rd_out_d = rd_q;
                        done_d   = 1'b1;
                        state_d  = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            op_q     <= OP_MUL;
            rd_q     <= '0;
            cnt_q    <= '0;
            acc_q    <= '0;
            opnd_q   <= '0;
            neg_q    <= 1'b0;
            result_q <= '0;
            rd_out_q <= '0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            rd_q     <= rd_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opnd_q   <= opnd_d;
            neg_q    <= neg_d;
            result_q <= result_d;
            rd_out_q <= rd_out_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
        end
    end

    // Stall must react in the same cycle the instruction appears in ID/EX
    assign bus.stall_req = ((state_q == ST_IDLE) && bus.start && !bus.flush) ||
                           (state_q == ST_CALC);
    assign bus.result    = result_q;
    assign bus.rd_out    = rd_out_q;
    assign bus.done      = done_q;
    assign bus.busy      = busy_q;

endmodule
